// File: rtl/uart_apb_master_pkg.sv
// Shared types for the UART APB master: transfer FSM state encoding.
package uart_apb_master_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/uart_apb_master_tmo.sv
// ACCESS wait-state counter for the UART APB master; built only when
// UART_APB_TIMEOUT_EN is defined.
module uart_apb_master_tmo #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Look-ahead: this wait cycle is the one that brings the count to the limit.
  assign expired_o = inc_i && (cnt_q == Limit);

endmodule

// File: rtl/uart_apb_master.sv
// APB requester: one valid/ready command becomes one SETUP/ACCESS transfer and one response.
// Optional ACCESS timeout is enabled by defining UART_APB_TIMEOUT_EN.
module uart_apb_master
  import uart_apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                pclk,
  input  logic                preset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr
);

  apb_state_e state_q, state_d;

  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] strb_q, strb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                tmo_expired;
  logic                on_bus;

`ifdef UART_APB_TIMEOUT_EN
  logic tmo_clr, tmo_inc;

  assign tmo_clr = (state_q == StSetup);
  assign tmo_inc = (state_q == StAccess) && !pready;

  uart_apb_master_tmo #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk_i    (pclk),
    .rst_ni   (preset_n),
    .clr_i    (tmo_clr),
    .inc_i    (tmo_inc),
    .expired_o(tmo_expired)
  );
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT_CYC == 0);
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          strb_d  = cmd_strb;
          state_d = StSetup;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        // Normal completion takes priority over a timeout in the same cycle.
        if (pready) begin
          rdata_d = write_q ? '0 : prdata;
          err_d   = pslverr;
          state_d = StResp;
        end else if (tmo_expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign on_bus    = (state_q == StSetup) || (state_q == StAccess);
  assign cmd_ready = (state_q == StIdle);
  assign psel      = on_bus;
  assign penable   = (state_q == StAccess);
  assign pwrite    = on_bus && write_q;
  assign paddr     = on_bus ? addr_q : '0;
  assign pwdata    = (on_bus && write_q) ? wdata_q : '0;
  assign pstrb     = (on_bus && write_q) ? strb_q : '0;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed self-checking bench for uart_apb_master (timeout case under UART_APB_TIMEOUT_EN).
module tb_uart_apb_master;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 pclk = ~pclk;

  uart_apb_master #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .TIMEOUT_CYC(4)
  ) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_strb (cmd_strb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pstrb    (pstrb),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_strb  = strb;
  endtask

  initial begin
    preset_n  = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    cyc();
    cyc();
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_psel", psel, 0);
    check_eq("rst_penable", penable, 0);
    check_eq("rst_paddr", paddr, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    preset_n = 1'b1;
    cyc();

    // Zero-wait write.
    pready = 1'b1;
    send(1'b1, 32'h04, 32'hA5, 4'h1);
    check_eq("wr_cmd_ready", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
    check_eq("wr_setup_psel", psel, 1);
    check_eq("wr_setup_penable", penable, 0);
    check_eq("wr_setup_paddr", paddr, 32'h04);
    check_eq("wr_setup_pwrite", pwrite, 1);
    check_eq("wr_setup_pwdata", pwdata, 32'hA5);
    check_eq("wr_setup_pstrb", pstrb, 4'h1);
    check_eq("wr_setup_cmd_ready", cmd_ready, 0);
    cyc();
    check_eq("wr_access_penable", penable, 1);
    check_eq("wr_access_rsp_valid", rsp_valid, 0);
    cyc();
    check_eq("wr_resp_valid", rsp_valid, 1);
    check_eq("wr_resp_err", rsp_err, 0);
    check_eq("wr_resp_rdata", rsp_rdata, 0);
    check_eq("wr_resp_psel", psel, 0);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    check_eq("wr_idle_rsp_valid", rsp_valid, 0);
    check_eq("wr_idle_cmd_ready", cmd_ready, 1);

    // Read with 3 wait states; write data/strobe must not leak onto the bus.
    pready = 1'b0;
    prdata = 32'hFFFF_FFFF;
    send(1'b0, 32'h08, 32'hDEAD_BEEF, 4'hF);
    cyc();
    cmd_valid = 1'b0;
    check_eq("rd_setup_pstrb", pstrb, 0);
    check_eq("rd_setup_pwdata", pwdata, 0);
    check_eq("rd_setup_pwrite", pwrite, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_eq("rd_access_penable", penable, 1);
      check_eq("rd_access_paddr", paddr, 32'h08);
      check_eq("rd_access_pstrb", pstrb, 0);
      if (i == 3) begin
        pready = 1'b1;
        prdata = 32'h0000_0037;
      end
    end
    cyc();
    pready = 1'b0;
    prdata = 32'h1234_5678;
    check_eq("rd_resp_valid", rsp_valid, 1);
    check_eq("rd_resp_rdata", rsp_rdata, 32'h37);
    check_eq("rd_resp_err", rsp_err, 0);

    // Back-pressure: response held, new command held off.
    send(1'b0, 32'h0C, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_eq("hold_cmd_ready", cmd_ready, 0);
      check_eq("hold_psel", psel, 0);
      check_eq("hold_rsp_valid", rsp_valid, 1);
      check_eq("hold_rsp_rdata", rsp_rdata, 32'h37);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    check_eq("held_cmd_ready", cmd_ready, 1);

    // Held command goes out; slave reports an error.
    pready  = 1'b1;
    pslverr = 1'b1;
    prdata  = 32'h99;
    cyc();
    cmd_valid = 1'b0;
    check_eq("err_setup_paddr", paddr, 32'h0C);
    cyc();
    cyc();
    pready  = 1'b0;
    pslverr = 1'b0;
    check_eq("err_resp_err", rsp_err, 1);
    check_eq("err_resp_rdata", rsp_rdata, 32'h99);
    send(1'b1, 32'h10, 32'h55, 4'h3);
    cyc();
    check_eq("err_hold_cmd_ready", cmd_ready, 0);
    check_eq("err_hold_psel", psel, 0);
    check_eq("err_hold_rsp_err", rsp_err, 1);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;

    // Reset in the middle of ACCESS abandons the transfer.
    cyc();
    cmd_valid = 1'b0;
    check_eq("mid_setup_paddr", paddr, 32'h10);
    cyc();
    check_eq("mid_access_penable", penable, 1);
    preset_n = 1'b0;
    cyc();
    check_eq("mid_rst_psel", psel, 0);
    check_eq("mid_rst_penable", penable, 0);
    check_eq("mid_rst_rsp_valid", rsp_valid, 0);
    check_eq("mid_rst_cmd_ready", cmd_ready, 1);
    preset_n = 1'b1;
    pready   = 1'b1;
    cyc();
    cyc();
    check_eq("mid_after_rsp_valid", rsp_valid, 0);
    check_eq("mid_after_psel", psel, 0);
    pready = 1'b0;

    // Stuck pready: abort with TIMEOUT_CYC=4, otherwise wait indefinitely.
    prdata = 32'hCAFE;
    send(1'b0, 32'h14, 32'h0, 4'h0);
    cyc();
    cmd_valid = 1'b0;
`ifdef UART_APB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_eq("tmo_access_penable", penable, 1);
    end
    cyc();
    check_eq("tmo_resp_valid", rsp_valid, 1);
    check_eq("tmo_resp_err", rsp_err, 1);
    check_eq("tmo_resp_rdata", rsp_rdata, 0);
    check_eq("tmo_resp_psel", psel, 0);
`else
    for (int i = 0; i < 8; i++) begin
      cyc();
      check_eq("notmo_access_penable", penable, 1);
      check_eq("notmo_rsp_valid", rsp_valid, 0);
    end
    pready = 1'b1;
    cyc();
    pready = 1'b0;
    check_eq("notmo_resp_rdata", rsp_rdata, 32'hCAFE);
    check_eq("notmo_resp_err", rsp_err, 0);
`endif
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    check_eq("final_cmd_ready", cmd_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
